// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants for the seven-segment scanner: default digit
//                count, active-low segment codes (seg[0]=a .. seg[6]=g),
//                blank/anode-off levels and the scanner state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Default number of multiplexed digits
    localparam int DEF_NUM_DIGITS = 4;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // All segments dark
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Level of a single anode select when its digit is off (anodes are active-low)
    localparam logic AN_OFF = 1'b1;

    // Scanner state encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/hex_to_seven_segment.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seven_segment
//  Description : Combinational hex nibble to active-low seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seven_segment
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_code
);

    // Map each hex digit onto its standard segment pattern
    always_comb begin
        seg_code = SEG_BLANK;
        case (nibble)
            4'h0: seg_code = SEG_0;
            4'h1: seg_code = SEG_1;
            4'h2: seg_code = SEG_2;
            4'h3: seg_code = SEG_3;
            4'h4: seg_code = SEG_4;
            4'h5: seg_code = SEG_5;
            4'h6: seg_code = SEG_6;
            4'h7: seg_code = SEG_7;
            4'h8: seg_code = SEG_8;
            4'h9: seg_code = SEG_9;
            4'hA: seg_code = SEG_A;
            4'hB: seg_code = SEG_B;
            4'hC: seg_code = SEG_C;
            4'hD: seg_code = SEG_D;
            4'hE: seg_code = SEG_E;
            4'hF: seg_code = SEG_F;
            default: seg_code = SEG_BLANK;
        endcase
    end

endmodule : hex_to_seven_segment
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scanner
//  Description : Time-multiplexes a hex value onto a common-anode multi-digit
//                seven-segment display, one digit per clk_en strobe. The value,
//                decimal points and blanking enable are captured once per frame
//                so a frame never mixes old and new data. After every digit
//                switch all anodes stay off for BLANK_CYCLES clocks to avoid
//                ghosting. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    clk_en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [SW-1:0]         c_last_sel   = SW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0]         c_one_sel    = SW'(1);
    localparam logic [GW-1:0]         c_guard_load = GW'(BLANK_CYCLES);
    localparam logic [GW-1:0]         c_guard_one  = GW'(1);
    localparam logic [NUM_DIGITS-1:0] c_an_off     = {NUM_DIGITS{AN_OFF}};

    scan_state_t             r_state;
    logic [SW-1:0]           r_digit_sel;
    logic [GW-1:0]           r_guard;
    logic [4*NUM_DIGITS-1:0] r_shadow_value;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_shadow_lz;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic [SW-1:0]           w_next_sel;
    logic                    w_snap;
    logic [4*NUM_DIGITS-1:0] w_src_value;
    logic [NUM_DIGITS-1:0]   w_src_dp;
    logic                    w_src_lz;
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_blank;
    logic [6:0]              w_seg_code;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [NUM_DIGITS-1:0]   w_an_cur;

    // Digit that the next strobe selects; leaving IDLE always starts at digit 0
    always_comb begin
        w_next_sel = '0;
        if (r_state == SCAN && r_digit_sel != c_last_sel) begin
            w_next_sel = r_digit_sel + c_one_sel;
        end
    end

    // A strobe landing on digit 0 opens a new frame, so decode straight from the
    // live inputs that are being captured on that very edge
    assign w_snap      = (w_next_sel == '0);
    assign w_src_value = w_snap ? value : r_shadow_value;
    assign w_src_dp    = w_snap ? dp    : r_shadow_dp;
    assign w_src_lz    = w_snap ? lz_en : r_shadow_lz;

    // Per digit: are this nibble and every more-significant nibble all zero
    always_comb begin
        w_upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_upper_zero[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (w_src_value[j*4 +: 4] != 4'h0) begin
                    w_upper_zero[i] = 1'b0;
                end
            end
        end
    end

    // Select nibble, decimal point and blanking for the upcoming digit; digit 0
    // is never blanked so an all-zero value still shows a single zero
    always_comb begin
        w_nibble = 4'h0;
        w_dp_bit = 1'b0;
        w_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_next_sel == SW'(i)) begin
                w_nibble = w_src_value[i*4 +: 4];
                w_dp_bit = w_src_dp[i];
                w_blank  = (i != 0) && w_src_lz && w_upper_zero[i];
            end
        end
    end

    // Active-low one-hot anode patterns for the upcoming and current digit
    always_comb begin
        w_an_next = c_an_off;
        w_an_cur  = c_an_off;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_next[i] = (w_next_sel  != SW'(i));
            w_an_cur[i]  = (r_digit_sel != SW'(i));
        end
    end

    hex_to_seven_segment u_decoder (
        .nibble   (w_nibble),
        .seg_code (w_seg_code)
    );

    // Scan state, frame capture, guard countdown and registered display outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state        <= IDLE;
            r_digit_sel    <= '0;
            r_guard        <= '0;
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_shadow_lz    <= 1'b0;
            r_an           <= c_an_off;
            r_seg          <= SEG_BLANK;
            r_dp_n         <= 1'b1;
            r_frame_start  <= 1'b0;
        end else if (clk_en) begin
            r_state       <= SCAN;
            r_digit_sel   <= w_next_sel;
            r_frame_start <= w_snap;
            if (w_snap) begin
                r_shadow_value <= value;
                r_shadow_dp    <= dp;
                r_shadow_lz    <= lz_en;
            end
            r_seg  <= w_blank ? SEG_BLANK : w_seg_code;
            r_dp_n <= ~w_dp_bit;
            // A strobe inside a running guard simply restarts it, so a too-short
            // strobe period leaves the display dark rather than mis-lit
            if (BLANK_CYCLES == 0) begin
                r_an    <= w_an_next;
                r_guard <= '0;
            end else begin
                r_an    <= c_an_off;
                r_guard <= c_guard_load;
            end
        end else begin
            r_frame_start <= 1'b0;
            if (r_guard != '0) begin
                r_guard <= r_guard - c_guard_one;
                if (r_guard == c_guard_one) begin
                    r_an <= w_an_cur;
                end
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule : seven_segment_scanner
`default_nettype wire

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Downstream consumer of the 1 kHz clk_en strobe produced by the clock enabler.
- Time-multiplexes a 16-bit hex value onto a four-digit common-anode seven-segment display: one digit per clk_en strobe.
- Features: per-frame value snapshot (no tearing), leading-zero blanking, and an anti-ghosting guard interval in which all anodes are off after each digit switch.
- Sits between the display value source and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; value width = 4*NUM_DIGITS.
- BLANK_CYCLES, 16, clk cycles all anodes stay off after each digit switch; must be less than the clk_en period.

Ports:
- clk  input  1  system clock, 100 MHz.
- clr  input  1  synchronous active-high reset.
- clk_en  input  1  single-cycle digit-advance strobe from the clock enabler.
- value  input  16  hex value; nibble i drives digit i, digit 0 is rightmost.
- dp  input  4  decimal-point request per digit, active-high.
- lz_en  input  1  leading-zero blanking enable.
- an  output  4  anode selects, active-low.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp_n  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse when digit 0 of a new frame is selected.

Behaviour:
- Interface: one clock (clk); clr is synchronous and active-high; clr is sampled on posedge clk and has priority over clk_en.
- Reset state:
  - State IDLE, digit_sel=0, guard=0.
  - an=4'b1111, seg=7'h7F, dp_n=1, frame_start=0.
  - Shadow value, dp and lz registers cleared to 0.
- States:
  - IDLE: display dark.
  - SCAN: display active.
- Transitions:
  - IDLE→SCAN on the first clk_en after reset.
  - SCAN→IDLE only on clr.
- Digit advance, on each edge sampling clk_en=1:
  - From IDLE: digit_sel=0. From SCAN: digit_sel increments, wrapping NUM_DIGITS-1→0.
  - Whenever the new digit_sel is 0 (including the IDLE exit), value, dp and lz_en are snapshotted into shadow registers on the same edge, and frame_start=1 for exactly that cycle.
  - seg and dp_n update on the same edge to the new digit. For digit 0 of a new frame they reflect the value sampled at that edge.
  - On the same edge, an=4'b1111 and guard loads BLANK_CYCLES.
- Guard interval:
  - guard decrements once per clk while nonzero; an stays 4'b1111 while guard≠0.
  - an becomes ~(1<<digit_sel) on the edge where guard reaches 0, i.e. exactly BLANK_CYCLES cycles after the clk_en edge.
  - BLANK_CYCLES=0: an asserts on the clk_en edge itself.
  - A clk_en arriving with guard≠0 still advances the digit and reloads guard. A misconfigured period therefore leaves the display dark; it must never show a wrong digit.
- Decode: hex 0–F, standard patterns.
  - Active-low codes: 0=7'h40, 1=7'h79, 2=7'h24, 5=7'h12, 8=7'h00, A=7'h08; all remaining codes defined in the package.
- Leading-zero blanking, when shadow lz=1:
  - Digit i>0 is blanked (seg=7'h7F) if shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - dp_n = ~shadow_dp[digit_sel], independent of blanking.
- Mid-frame changes to value, dp or lz_en do not affect the display until the next wrap to digit 0.
- clr mid-operation: next edge returns to the reset state regardless of clk_en or guard. The following clk_en starts a fresh frame at digit 0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package seven_seg_pkg:
  - NUM_DIGITS default.
  - Sixteen active-low segment code constants.
  - SEG_BLANK=7'h7F and AN_OFF constant.
  - IDLE/SCAN state encoding.
- Sub-module hex_to_seven_segment: combinational 4-bit nibble → 7-bit active-low code, instantiated once on the muxed shadow nibble.

Test Plan (bench drives a one-cycle clk_en every 20 clk; BLANK_CYCLES=4):
- Reset check: assert clr for 3 cycles, no clk_en → an=4'hF, seg=7'h7F, dp_n=1, frame_start=0, held until the first clk_en.
- Full-frame scan: value=16'h12A8, dp=4'b0100, lz_en=0 → per strobe:
  - an=1110 seg=7'h00
  - an=1101 seg=7'h08
  - an=1011 seg=7'h24 dp_n=0
  - an=0111 seg=7'h79
  - then wraps with a frame_start pulse.
- Leading-zero blanking: value=16'h0005 with lz_en=1 → digits 1–3 seg=7'h7F and digit 0 seg=7'h12. Same value with lz_en=0 → digits 1–3 seg=7'h40.
- No tearing: change value from 16'h1111 to 16'h2222 while digit 1 is shown → digits 2–3 still show 7'h79; the next frame shows 7'h24 on all digits.
- Guard interval: after each clk_en, an=4'hF for exactly 4 cycles, then one low bit; with BLANK_CYCLES=0, an switches directly on the strobe edge.
- clr priority: clr coincident with clk_en at digit 2 → reset outputs next edge; next clk_en gives an=1110 plus a frame_start pulse.
